// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the CPU memory arbiter.
//               Holds the arbiter FSM state encoding and the fixed byte
//               select used for instruction fetches (always a full word).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter states. The encoding is 2 bits wide.
  typedef enum logic [1:0] {
    ArbState_IDLE    = 2'd0,
    ArbState_SERVE_I = 2'd1,
    ArbState_SERVE_D = 2'd2
  } arb_state_e;

  // Instruction fetches always read both bytes of the word.
  localparam logic [1:0] C_FETCH_BYTESEL = 2'b11;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Merges the core's instruction-fetch and data master ports
//               onto one 16-bit memory/IO bus. The data port has priority.
//               An atomic lock keeps the bus on the data port. A burst
//               counter forces an instruction grant after DATA_BURST_MAX
//               consecutive unlocked data grants while a fetch is waiting.
// Ports       :
//   clk, reset                     - clock, async active-low reset
//   instr_m_*                      - fetch master (read-only, word access)
//   data_m_*, d_io, lock           - data master, IO select, atomic hold
//   q_m_*, q_io, q_b               - shared system bus, q_b=1 for data owner
// Parameters  :
//   DATA_BURST_MAX                 - 1..15, data grants before fetch forced
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [18:0] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,

  input  logic [18:0] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  input  logic        lock,

  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_io,
  output logic        q_b
);

  localparam logic [3:0] C_BURST_MAX = 4'(DATA_BURST_MAX);

  arb_state_e r_state;
  logic [3:0] r_dcnt;
  logic       r_locked;

  logic       w_serve_i;
  logic       w_serve_d;
  logic       w_dcnt_sat;

  assign w_serve_i  = (r_state == ArbState_SERVE_I);
  assign w_serve_d  = (r_state == ArbState_SERVE_D);
  assign w_dcnt_sat = (r_dcnt == C_BURST_MAX);

  // --------------------------------------------------------------------------
  // Grant FSM, burst counter and lock flag.
  // Every completed or aborted transfer returns through IDLE, so the memory
  // always sees access drop for at least one cycle between owners.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ArbState_IDLE;
      r_dcnt   <= 4'd0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ArbState_IDLE: begin
          if (!lock)
            r_locked <= 1'b0;
          // No fetch waiting: the starvation history no longer matters.
          if (!instr_m_access)
            r_dcnt <= 4'd0;

          // A locked sequence never yields to the fetch port, not even
          // when the burst counter is saturated.
          if (r_locked && data_m_access)
            r_state <= ArbState_SERVE_D;
          else if (!r_locked && instr_m_access && w_dcnt_sat)
            r_state <= ArbState_SERVE_I;
          else if (data_m_access)
            r_state <= ArbState_SERVE_D;
          else if (!r_locked && instr_m_access)
            r_state <= ArbState_SERVE_I;
        end

        ArbState_SERVE_D: begin
          if (q_m_ack) begin
            r_state  <= ArbState_IDLE;
            r_locked <= lock;
            if (instr_m_access && !lock && !w_dcnt_sat)
              r_dcnt <= r_dcnt + 4'd1;
          end else if (!data_m_access) begin
            // Master withdrew before completion; counter left untouched.
            r_state <= ArbState_IDLE;
          end
        end

        ArbState_SERVE_I: begin
          if (q_m_ack) begin
            r_state <= ArbState_IDLE;
            r_dcnt  <= 4'd0;
          end else if (!instr_m_access) begin
            r_state <= ArbState_IDLE;
          end
        end

        default: r_state <= ArbState_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus steering. The grant is the registered state; the owning master's
  // request fields pass straight through so the bus tracks that master
  // and never reflects the other one.
  // --------------------------------------------------------------------------
  always_comb begin
    q_m_addr    = 19'd0;
    q_m_wr_en   = 1'b0;
    q_m_bytesel = 2'b00;
    q_io        = 1'b0;
    q_m_access  = 1'b0;
    q_b         = 1'b0;
    case (r_state)
      ArbState_SERVE_D: begin
        q_m_addr    = data_m_addr;
        q_m_wr_en   = data_m_wr_en;
        q_m_bytesel = data_m_bytesel;
        q_io        = d_io;
        q_m_access  = data_m_access;
        q_b         = 1'b1;
      end
      ArbState_SERVE_I: begin
        q_m_addr    = instr_m_addr;
        q_m_bytesel = C_FETCH_BYTESEL;
        q_m_access  = instr_m_access;
      end
      default: ;
    endcase
  end

  // Write data is qualified on the bus by q_m_wr_en, so it is not muxed.
  assign q_m_data_out    = data_m_data_out;

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

  // Only the current owner can see an ack; a stray ack in IDLE is dropped.
  assign instr_m_ack     = q_m_ack & w_serve_i;
  assign data_m_ack      = q_m_ack & w_serve_d;

endmodule : mem_arbiter
`default_nettype wire
